// File: rtl/sum_accumulator.sv
// sum_accumulator: totals a packet of adder sums (carry-out included) into an
// ACC_WIDTH accumulator. A packet closes on in_last or after MAX_BEATS beats.
// The result is held in HOLD until downstream takes it.
// Build option: define SUM_ACCUMULATOR_SATURATE_EN to clamp the accumulator to
// all ones on overflow. Without it the accumulator wraps. out_ovf flags the
// overflow in both builds.
module sum_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int MAX_BEATS  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH:0]            in_sum,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           out_acc,
  output logic [$clog2(MAX_BEATS+1)-1:0] out_count,
  output logic                           out_ovf
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                state, state_nxt;
  logic [ACC_WIDTH-1:0]  acc, acc_nxt;
  logic [CW-1:0]         count, count_nxt;
  logic                  ovf, ovf_nxt;
  logic [ACC_WIDTH:0]    in_ext;
  logic [ACC_WIDTH:0]    sum;
  logic                  accept;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  assign accept = in_valid && in_ready;
  // The extra top bit of the sum is the overflow indicator.
  assign in_ext = (ACC_WIDTH + 1)'(in_sum);
  assign sum    = {1'b0, acc} + in_ext;

  // State, accumulator, beat count and overflow flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next state and datapath. A packet's first beat overwrites the previous
  // result, and that clears ovf.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = in_ext[ACC_WIDTH-1:0];
          count_nxt = CW'(1);
          ovf_nxt   = 1'b0;
          state_nxt = (in_last || MAX_BEATS == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          ovf_nxt   = ovf | sum[ACC_WIDTH];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
          // Once the packet has overflowed, the accumulator stays clamped.
          acc_nxt   = ovf_nxt ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
          acc_nxt   = sum[ACC_WIDTH-1:0];
`endif
          count_nxt = count + CW'(1);
          state_nxt = (in_last || count_nxt == CW'(MAX_BEATS)) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator. Instance A uses the default parameters.
// Instance B uses ACC_WIDTH=9 to exercise overflow.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic reset;

  logic        in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a, out_ovf_a;
  logic [8:0]  in_sum_a;
  logic [15:0] out_acc_a;
  logic [4:0]  out_count_a;

  logic        in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, out_ovf_b;
  logic [8:0]  in_sum_b;
  logic [8:0]  out_acc_b;
  logic [4:0]  out_count_b;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] acc;
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  localparam int OVF2 = 511;
  localparam int OVF3 = 511;
`else
  localparam int OVF2 = 88;   // 600 mod 512
  localparam int OVF3 = 93;   // 605 mod 512
`endif

  sum_accumulator u_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_sum(in_sum_a), .in_last(in_last_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_acc(out_acc_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(9), .MAX_BEATS(16)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sum(in_sum_b), .in_last(in_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_acc(out_acc_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor A: compare each delivered result against the oldest expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!reset && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_a_unexpected: result acc=%0d with nothing expected", out_acc_a);
      end else begin
        e = qa.pop_front();
        check("sb_a_acc", 32'(out_acc_a), e.acc);
        check("sb_a_count", 32'(out_count_a), e.cnt);
        check("sb_a_ovf", 32'(out_ovf_a), 32'(e.ovf));
      end
    end
  end

  // Monitor B: the same comparison for the narrow-accumulator instance.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!reset && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_b_unexpected: result acc=%0d with nothing expected", out_acc_b);
      end else begin
        e = qb.pop_front();
        check("sb_b_acc", 32'(out_acc_b), e.acc);
        check("sb_b_count", 32'(out_count_b), e.cnt);
        check("sb_b_ovf", 32'(out_ovf_b), 32'(e.ovf));
      end
    end
  end

  task automatic push(input bit b, input int acc, input int cnt, input bit ovf);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt;
    e.ovf = ovf;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic beat(input bit b, input int s, input bit last);
    if (b) begin
      in_valid_b = 1'b1;
      in_sum_b = s[8:0];
      in_last_b = last;
    end else begin
      in_valid_a = 1'b1;
      in_sum_a = s[8:0];
      in_last_a = last;
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_last_a = 1'b0;
    in_valid_b = 1'b0; in_last_b = 1'b0;
  endtask

  // Wait a bounded time for a result, then take it for one cycle.
  task automatic drain(input bit b);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!(b ? out_valid_b : out_valid_a) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: out_valid %0d, expected 1", b ? out_valid_b : out_valid_a);
    end
    if (b) out_ready_b = 1'b1;
    else   out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid_a = 0; in_last_a = 0; in_sum_a = '0; out_ready_a = 0;
    in_valid_b = 0; in_last_b = 0; in_sum_b = '0; out_ready_b = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_a), 1);
    check("rst_out_valid", 32'(out_valid_a), 0);
    check("rst_acc", 32'(out_acc_a), 0);
    check("rst_count", 32'(out_count_a), 0);
    check("rst_ovf", 32'(out_ovf_a), 0);
    @(posedge clk); #1;

    // 10, 20, 30(last). An idle gap in ACCUM holds state.
    beat(0, 10, 0);
    repeat (3) @(posedge clk);
    #1;
    check("gap_count", 32'(out_count_a), 1);
    beat(0, 20, 0);
    push(0, 60, 3, 0);
    beat(0, 30, 1);
    @(negedge clk);
    check("latency_valid", 32'(out_valid_a), 1);
    drain(0);

    // 16 x 511 with no last closes on MAX_BEATS.
    push(0, 8176, 16, 0);
    for (int i = 0; i < 16; i++) beat(0, 511, 0);
    @(negedge clk);
    check("max_in_ready", 32'(in_ready_a), 0);
    check("max_valid", 32'(out_valid_a), 1);

    // HOLD with out_ready low and in_valid high: stable, nothing accepted.
    in_valid_a = 1'b1; in_sum_a = 9'd99; in_last_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_acc", 32'(out_acc_a), 8176);
      check("hold_count", 32'(out_count_a), 16);
      check("hold_valid", 32'(out_valid_a), 1);
    end
    @(posedge clk); #1 out_ready_a = 1'b1;
    @(posedge clk); #1 out_ready_a = 1'b0;
    in_valid_a = 1'b0; in_last_a = 1'b0;
    @(negedge clk);
    check("release_valid", 32'(out_valid_a), 0);
    check("release_ready", 32'(in_ready_a), 1);
    check("release_no_beat", 32'(out_acc_a), 8176);
    @(posedge clk); #1;
    push(0, 7, 1, 0);
    beat(0, 7, 1);
    drain(0);

    // Reset mid-packet discards it and wins over a handshake.
    beat(0, 1, 0);
    beat(0, 2, 0);
    reset = 1'b1;
    in_valid_a = 1'b1; in_sum_a = 9'd3; in_last_a = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid_a = 1'b0; in_last_a = 1'b0;
    @(negedge clk);
    check("mrst_valid", 32'(out_valid_a), 0);
    check("mrst_ready", 32'(in_ready_a), 1);
    check("mrst_acc", 32'(out_acc_a), 0);
    check("mrst_count", 32'(out_count_a), 0);
    @(posedge clk); #1;
    push(0, 5, 1, 0);
    beat(0, 5, 1);
    drain(0);

    // Single zero beat.
    push(0, 0, 1, 0);
    beat(0, 0, 1);
    drain(0);

    // Narrow accumulator: overflow, clamp/wrap, then ovf clears on the next packet.
    push(1, OVF2, 2, 1);
    beat(1, 300, 0);
    beat(1, 300, 1);
    drain(1);
    push(1, OVF3, 3, 1);
    beat(1, 300, 0);
    beat(1, 300, 0);
    beat(1, 5, 1);
    drain(1);
    push(1, 4, 1, 0);
    beat(1, 4, 1);
    drain(1);

    repeat (2) @(posedge clk);
    check("sb_a_leftover", 32'(qa.size()), 0);
    check("sb_b_leftover", 32'(qb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
